// File: rtl/dram_cmd_decoder_pkg.sv
// Shared definitions for the emulated-DRAM command decoder and the SSRAM
// burst controller that consumes its phrase requests.
package dram_cmd_decoder_pkg;

  localparam int ROW_BITS = 10;
  localparam int COL_BITS = 8;
  localparam int ADDR_W   = ROW_BITS + COL_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } dec_state_e;

  // Interleave lane strobes into {uw3,lw3,uw2,lw2,uw1,lw1,uw0,lw0}
  function automatic logic [7:0] pack_be_n(input logic [3:0] uw_n,
                                           input logic [3:0] lw_n);
    logic [7:0] be;
    be = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      be[2*i]   = lw_n[i];
      be[2*i+1] = uw_n[i];
    end
    return be;
  endfunction

endpackage

// File: rtl/dram_strobe_edge.sv
// Edge detection on the RAS/CAS strobes plus CAS-before-RAS classification.
// The strobes are already synchronous to the system clock.
module dram_strobe_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ras_n_i,
  input  logic cas_n_i,
  output logic ras_fall_o,
  output logic cas_fall_o,
  output logic cas_rise_o,
  output logic cbr_o,
  output logic row_latch_o
);

  logic ras_prev_q;
  logic cas_prev_q;

  // Previous strobe levels, idle-high out of reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ras_prev_q <= 1'b1;
      cas_prev_q <= 1'b1;
    end else begin
      ras_prev_q <= ras_n_i;
      cas_prev_q <= cas_n_i;
    end
  end

  assign ras_fall_o  = ras_prev_q & ~ras_n_i;
  assign cas_fall_o  = cas_prev_q & ~cas_n_i;
  assign cas_rise_o  = ~cas_prev_q & cas_n_i;
  assign cbr_o       = ras_fall_o & ~cas_n_i;
  assign row_latch_o = ras_fall_o & cas_n_i;

endmodule

// File: rtl/dram_cmd_decoder.sv
// Reconstructs DRAM row/column accesses from the core's strobes and issues one
// phrase request per CAS access; returns read data onto the core data pins.
module dram_cmd_decoder
  import dram_cmd_decoder_pkg::*;
(
  input  logic                sys_clk,
  input  logic                xreset,
  input  logic                fdram,
  input  logic [ROW_BITS-1:0] dram_a,
  input  logic                dram_ras_n,
  input  logic                dram_cas_n,
  input  logic [3:0]          dram_oe_n,
  input  logic [3:0]          dram_uw_n,
  input  logic [3:0]          dram_lw_n,
  input  logic [63:0]         dram_d,
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_we,
  output logic [ADDR_W-1:0]   req_addr,
  output logic [7:0]          req_be_n,
  output logic [63:0]         req_wdata,
  input  logic                rsp_valid,
  input  logic [63:0]         rsp_data,
  output logic [63:0]         dram_q,
  output logic [3:0]          dram_oe,
  output logic                busy,
  output logic [15:0]         refresh_cnt,
  output logic                overrun
);

  logic ras_fall, cas_fall, cas_rise, cbr, row_latch;

  dram_strobe_edge u_edge (
    .clk_i       (sys_clk),
    .rst_i       (xreset),
    .ras_n_i     (dram_ras_n),
    .cas_n_i     (dram_cas_n),
    .ras_fall_o  (ras_fall),
    .cas_fall_o  (cas_fall),
    .cas_rise_o  (cas_rise),
    .cbr_o       (cbr),
    .row_latch_o (row_latch)
  );

  dec_state_e          state_q;
  logic [ROW_BITS-1:0] row_q;
  logic [3:0]          oe_n_q;
  logic                rdy_q, discard_q, overrun_q, busy_q;
  logic                req_valid_q, req_we_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [7:0]          req_be_n_q;
  logic [63:0]         req_wdata_q, dram_q_q;
  logic [3:0]          dram_oe_q;
  logic [15:0]         refresh_cnt_q;

  logic is_rd, is_wr, cas_req, access;

  // A RAS fall in the same cycle as a CAS fall is a refresh, never an access
  assign is_rd   = ~&dram_oe_n;
  assign is_wr   = ~&(dram_uw_n & dram_lw_n);
  assign cas_req = cas_fall & ~dram_ras_n & fdram & ~cbr;
  assign access  = cas_req & (is_rd | is_wr);

  // Access FSM, row/refresh tracking and read-data return
  always_ff @(posedge sys_clk) begin
    if (xreset) begin
      state_q       <= IDLE;
      row_q         <= '0;
      oe_n_q        <= 4'hF;
      rdy_q         <= 1'b0;
      discard_q     <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
      req_valid_q   <= 1'b0;
      req_we_q      <= 1'b0;
      req_addr_q    <= '0;
      req_be_n_q    <= 8'hFF;
      req_wdata_q   <= 64'd0;
      dram_q_q      <= 64'd0;
      dram_oe_q     <= 4'h0;
      refresh_cnt_q <= 16'd0;
    end else begin
      if (row_latch) row_q <= dram_a;
      if (cbr) refresh_cnt_q <= refresh_cnt_q + 16'd1;
      if (cas_rise) rdy_q <= 1'b0;
      if (access && (state_q != IDLE)) overrun_q <= 1'b1;
      dram_oe_q <= (~dram_cas_n && rdy_q) ? ~oe_n_q : 4'h0;

      case (state_q)
        IDLE: begin
          if (access) begin
            req_valid_q <= 1'b1;
            req_we_q    <= ~is_rd;
            req_addr_q  <= {row_q, dram_a[COL_BITS-1:0]};
            req_be_n_q  <= pack_be_n(dram_uw_n, dram_lw_n);
            req_wdata_q <= dram_d;
            oe_n_q      <= dram_oe_n;
            busy_q      <= 1'b1;
            discard_q   <= 1'b0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cas_rise && !req_we_q) discard_q <= 1'b1;
          if (req_ready) begin
            req_valid_q <= 1'b0;
            if (req_we_q) begin
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              state_q <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (cas_rise) discard_q <= 1'b1;
          if (rsp_valid) begin
            busy_q <= 1'b0;
            if (discard_q) begin
              discard_q <= 1'b0;
              state_q   <= IDLE;
            end else begin
              dram_q_q <= rsp_data;
              rdy_q    <= ~cas_rise;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          if (dram_cas_n) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_valid   = req_valid_q;
  assign req_we      = req_we_q;
  assign req_addr    = req_addr_q;
  assign req_be_n    = req_be_n_q;
  assign req_wdata   = req_wdata_q;
  assign dram_q      = dram_q_q;
  assign dram_oe     = dram_oe_q;
  assign busy        = busy_q;
  assign refresh_cnt = refresh_cnt_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_dram_cmd_decoder.sv
// Directed bench for dram_cmd_decoder: reads, writes with backpressure, page
// mode, CBR refresh with wrap, abort and reset during an issued request.
module tb_dram_cmd_decoder;

  logic        sys_clk = 1'b0;
  logic        xreset, fdram;
  logic [9:0]  dram_a;
  logic        dram_ras_n, dram_cas_n;
  logic [3:0]  dram_oe_n, dram_uw_n, dram_lw_n;
  logic [63:0] dram_d;
  logic        req_valid, req_ready, req_we;
  logic [17:0] req_addr;
  logic [7:0]  req_be_n;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_data, dram_q;
  logic [3:0]  dram_oe;
  logic        busy, overrun;
  logic [15:0] refresh_cnt;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int hs_base;

  dram_cmd_decoder dut (
    .sys_clk(sys_clk), .xreset(xreset), .fdram(fdram), .dram_a(dram_a),
    .dram_ras_n(dram_ras_n), .dram_cas_n(dram_cas_n), .dram_oe_n(dram_oe_n),
    .dram_uw_n(dram_uw_n), .dram_lw_n(dram_lw_n), .dram_d(dram_d),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be_n(req_be_n), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .dram_q(dram_q),
    .dram_oe(dram_oe), .busy(busy), .refresh_cnt(refresh_cnt),
    .overrun(overrun)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (req_valid && req_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic page_write(input logic [7:0] col, input logic [17:0] exp_addr);
    dram_a = {2'b00, col};
    dram_lw_n = 4'h0;
    dram_cas_n = 1'b0;
    step();
    chk("page_valid", {63'd0, req_valid}, 64'd1);
    chk("page_addr", {46'd0, req_addr}, {46'd0, exp_addr});
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("page_accepted", {63'd0, req_valid}, 64'd0);
    dram_cas_n = 1'b1;
    dram_lw_n = 4'hF;
    step();
  endtask

  initial begin
    xreset = 1'b1; fdram = 1'b0; dram_a = 10'h000;
    dram_ras_n = 1'b1; dram_cas_n = 1'b1;
    dram_oe_n = 4'hF; dram_uw_n = 4'hF; dram_lw_n = 4'hF; dram_d = 64'd0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 64'd0;
    step(); step();
    xreset = 1'b0;
    chk("rst_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_we", {63'd0, req_we}, 64'd0);
    chk("rst_addr", {46'd0, req_addr}, 64'd0);
    chk("rst_be_n", {56'd0, req_be_n}, 64'hFF);
    chk("rst_wdata", req_wdata, 64'd0);
    chk("rst_q", dram_q, 64'd0);
    chk("rst_oe", {60'd0, dram_oe}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_refresh", {48'd0, refresh_cnt}, 64'd0);

    // Read with ready asserted after issue
    dram_a = 10'h155; dram_ras_n = 1'b0;
    step();
    dram_a = 10'h0A3; dram_cas_n = 1'b0; dram_oe_n = 4'h0; fdram = 1'b1;
    step();
    chk("rd_valid", {63'd0, req_valid}, 64'd1);
    chk("rd_we", {63'd0, req_we}, 64'd0);
    chk("rd_addr", {46'd0, req_addr}, 64'h155A3);
    chk("rd_busy", {63'd0, busy}, 64'd1);
    step();
    chk("rd_hold", {63'd0, req_valid}, 64'd1);
    req_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    req_ready = 1'b0; rsp_valid = 1'b0;
    chk("rd_hs_drop", {63'd0, req_valid}, 64'd0);
    chk("rd_early_rsp_q", dram_q, 64'd0);
    chk("rd_early_rsp_busy", {63'd0, busy}, 64'd1);
    rsp_valid = 1'b1; rsp_data = 64'h0123_4567_89AB_CDEF;
    step();
    rsp_valid = 1'b0;
    chk("rd_q", dram_q, 64'h0123_4567_89AB_CDEF);
    chk("rd_oe_latency", {60'd0, dram_oe}, 64'd0);
    chk("rd_busy_done", {63'd0, busy}, 64'd0);
    step();
    chk("rd_oe", {60'd0, dram_oe}, 64'hF);
    dram_cas_n = 1'b1; dram_oe_n = 4'hF;
    step();
    chk("rd_oe_cas_hi", {60'd0, dram_oe}, 64'd0);
    dram_ras_n = 1'b1;
    step();

    // Write held off by backpressure for five cycles
    dram_a = 10'h02A; dram_ras_n = 1'b0;
    step();
    dram_a = 10'h03C; dram_cas_n = 1'b0;
    dram_uw_n = 4'b1110; dram_lw_n = 4'b1111; dram_d = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    hs_base = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("wr_valid", {63'd0, req_valid}, 64'd1);
      chk("wr_we", {63'd0, req_we}, 64'd1);
      chk("wr_addr", {46'd0, req_addr}, 64'h02A3C);
      chk("wr_be_n", {56'd0, req_be_n}, 64'hFD);
      chk("wr_wdata", req_wdata, 64'hDEAD_BEEF_CAFE_F00D);
      chk("wr_busy", {63'd0, busy}, 64'd1);
      dram_d = ~dram_d; dram_a = dram_a + 10'd1; dram_uw_n = 4'hF;
      step();
    end
    chk("wr_still_valid", {63'd0, req_valid}, 64'd1);
    req_ready = 1'b1;
    step();
    chk("wr_hs_drop", {63'd0, req_valid}, 64'd0);
    chk("wr_busy_drop", {63'd0, busy}, 64'd0);
    step(); step();
    req_ready = 1'b0;
    chk("wr_one_handshake", 64'(hs_cnt - hs_base), 64'd1);
    dram_cas_n = 1'b1;
    step();
    dram_ras_n = 1'b1;
    step();

    // Page mode under one row
    dram_a = 10'h3FF; dram_ras_n = 1'b0;
    step();
    page_write(8'h00, 18'h3FF00);
    page_write(8'h01, 18'h3FF01);
    page_write(8'hFF, 18'h3FFFF);
    dram_ras_n = 1'b1;
    step();

    // CAS-before-RAS refresh, then wrap from all-ones
    dram_cas_n = 1'b0;
    step();
    dram_ras_n = 1'b0;
    step();
    chk("cbr_count", {48'd0, refresh_cnt}, 64'd1);
    chk("cbr_no_req", {63'd0, req_valid}, 64'd0);
    chk("cbr_not_busy", {63'd0, busy}, 64'd0);
    dram_ras_n = 1'b1; dram_cas_n = 1'b1;
    step();
    force dut.refresh_cnt_q = 16'hFFFF;
    step();
    release dut.refresh_cnt_q;
    step();
    chk("cbr_preset", {48'd0, refresh_cnt}, 64'hFFFF);
    dram_cas_n = 1'b0;
    step();
    dram_ras_n = 1'b0;
    step();
    chk("cbr_wrap", {48'd0, refresh_cnt}, 64'd0);
    chk("cbr_wrap_no_req", {63'd0, req_valid}, 64'd0);
    dram_ras_n = 1'b1; dram_cas_n = 1'b1;
    step();

    // Abort: CAS rises before the response arrives
    dram_a = 10'h111; dram_ras_n = 1'b0;
    step();
    dram_a = 10'h022; dram_oe_n = 4'h0; dram_cas_n = 1'b0;
    step();
    chk("ab_addr", {46'd0, req_addr}, 64'h11122);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("ab_busy", {63'd0, busy}, 64'd1);
    dram_cas_n = 1'b1; dram_oe_n = 4'hF;
    step();
    chk("ab_oe_pre", {60'd0, dram_oe}, 64'd0);
    rsp_valid = 1'b1; rsp_data = 64'h1111;
    step();
    rsp_valid = 1'b0;
    chk("ab_q_kept", dram_q, 64'h0123_4567_89AB_CDEF);
    chk("ab_busy_clr", {63'd0, busy}, 64'd0);
    step();
    chk("ab_oe", {60'd0, dram_oe}, 64'd0);
    dram_a = 10'h033; dram_oe_n = 4'h0; dram_cas_n = 1'b0;
    step();
    chk("ab_idle_reissue", {63'd0, req_valid}, 64'd1);
    chk("ab_page_addr", {46'd0, req_addr}, 64'h11133);

    // Reset while the request is being offered
    xreset = 1'b1;
    step();
    xreset = 1'b0; dram_ras_n = 1'b1; dram_cas_n = 1'b1; dram_oe_n = 4'hF;
    chk("mrst_valid", {63'd0, req_valid}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_addr", {46'd0, req_addr}, 64'd0);
    chk("mrst_be_n", {56'd0, req_be_n}, 64'hFF);
    chk("mrst_q", dram_q, 64'd0);
    chk("mrst_refresh", {48'd0, refresh_cnt}, 64'd0);
    req_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 64'h5555_5555_5555_5555;
    step();
    req_ready = 1'b0; rsp_valid = 1'b0;
    chk("mrst_rsp_ignored", dram_q, 64'd0);
    chk("mrst_rsp_busy", {63'd0, busy}, 64'd0);
    step();
    chk("mrst_oe", {60'd0, dram_oe}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
